wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Write-side front end for the 32x32 register file. Merges the pipeline's single-cycle writeback stream with completions from the variable-latency load/multi-cycle unit (LSU) onto the register file's single write port. Buffers LSU results in a small in-order queue, resolves write-after-write ordering, and reports pending writes to the hazard logic. Drives the register file's `wr_en`/`wr_addr`/`wr_data` directly.

## Interface
- `DEPTH`, 4, LSU queue entries; must be a power of 2, at least 2.
- `STARVE_MAX`, 8, consecutive ALU-won cycles with a non-empty queue before a forced drain.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `alu_valid`  in  1  pipeline writeback valid; no backpressure except `alu_stall`.
- `alu_rd`  in  5  pipeline destination register.
- `alu_data`  in  32  pipeline result.
- `alu_stall`  out  1  pipeline must hold its writeback this cycle; `alu_valid` is ignored while high.
- `lsu_valid`  in  1  LSU result valid.
- `lsu_ready`  out  1  queue can accept.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_data`  in  32  LSU result.
- `wr_en`  out  1  to register file.
- `wr_addr`  out  5  to register file.
- `wr_data`  out  32  to register file.
- `rd_addr1`, `rd_addr2`  in  5 each  decode-stage source registers.
- `pend_hit1`, `pend_hit2`  out  1 each  a live queued write targets the source.
- `byp_valid1`, `byp_valid2`  out  1 each  bypass data valid (see Configuration).
- `byp_data1`, `byp_data2`  out  32 each  youngest live queued value for the source.

## Operation
- Queue entry: {live, rd, data}. FIFO order; head is oldest.
- LSU accept: `lsu_valid && lsu_ready`. `lsu_ready = !full && !reset`; a pop in the same cycle does not raise `lsu_ready` while full. An accept with `lsu_rd == 0` is consumed but not enqueued.
- Port arbitration each cycle, in priority order:
  1. `alu_stall`: pop head.
  2. `alu_valid && alu_rd != 0`: ALU write.
  3. Queue non-empty: pop head.
  4. Idle.
- ALU writes with `alu_rd == 0` are dropped; the port is treated as free.
- Popping a live entry produces a write. Popping a killed entry produces no write (`wr_en = 0`), but still consumes the cycle.
- WAW kill: an ALU write to rd X is younger than every queue entry, including one accepted in the same cycle. Every entry with rd X is marked not-live; a same-cycle accept of X is enqueued already killed.
- Starvation counter:
  - Increments on each cycle where the ALU wins while the queue is non-empty.
  - Clears on any pop or when the queue is empty.
  - Reaching `STARVE_MAX` asserts `alu_stall` the next cycle, for exactly one cycle; the counter then clears.
- `pend_hitN = 1` if some live entry has rd == `rd_addrN` and `rd_addrN != 0`. The current cycle's accept is excluded.

## Timing
- `wr_*` are registered. A write selected in cycle N appears in cycle N+1; the register file commits it on the negedge of N+1.
- Accept-to-earliest-write latency: 2 cycles (enqueue in N, pop in N+1, `wr_en` in N+2).
- `alu_stall` is driven from a register; `pend_hit*` and `byp_*` are combinational from queue state.
- Reset values:
  - `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`, `alu_stall = 0`, `lsu_ready = 0`.
  - Queue emptied, all entries not-live, counter 0, all hit and bypass outputs 0.
- Reset mid-operation discards queued writes; no write issues in the cycle after reset.
- Full: `lsu_ready = 0`, and LSU data is held by the LSU.
- Empty: `pend_hit* = 0`.
- Pointers wrap modulo `DEPTH`. Full/empty are distinguished by an extra pointer bit.

## Configuration
- `WB_BYPASS_EN` defined: for each read port, `byp_validN = pend_hitN`, and `byp_dataN` is the data of the youngest live matching entry.
- `WB_BYPASS_EN` undefined: `byp_valid*` and `byp_data*` are tied to 0; no comparator or priority-mux logic is built. `pend_hit*` is unaffected.

## Test plan
- Reset, then LSU writes x5 = 0x1234 with ALU idle -> `wr_en = 1`, `wr_addr = 5`, `wr_data = 0x1234` exactly 2 cycles after accept; `pend_hit1` is high for one cycle while `rd_addr1 = 5`.
- ALU writes every cycle; LSU fills the queue (DEPTH = 4) -> `lsu_ready = 0` after 4 accepts; `alu_stall` pulses once after 8 ALU-won cycles; head pops, with the head's rd/data on `wr_*` next cycle.
- LSU enqueues x7 = 0xAAAA; next cycle ALU writes x7 = 0xBBBB -> the register file sees only 0xBBBB; the later pop of the killed entry gives `wr_en = 0`.
- Same-cycle LSU accept and ALU write both targeting x9 -> the entry is enqueued killed; `pend_hit` stays 0 for x9; only the ALU value is written.
- Writes with `lsu_rd = 0` and `alu_rd = 0` -> no `wr_en`, nothing enqueued. With `WB_BYPASS_EN`, two queued x3 values 0x1 then 0x2 -> `byp_data1 = 0x2`.
- Assert reset with 3 entries queued -> the queue empties, no subsequent `wr_en`, and `lsu_ready = 1` in the first cycle after reset is released.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU writeback and an in-order LSU result queue onto one regfile write port (optional bypass: WB_BYPASS_EN).
// Latency: ALU write 1 cycle to wr_*, LSU accept to earliest wr_* 2 cycles.
// Backpressure: lsu_ready low while queue full; alu_stall pulses one cycle to force a drain after STARVE_MAX ALU wins.
module wb_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        byp_valid1,
  output logic        byp_valid2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0] q_live;
  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, count;
  logic [AW-1:0]    head_idx, tail_idx;
  logic [CW-1:0]    starve_cnt;
  logic             full, empty, accept, enq, alu_win, pop, enq_killed;
  logic [DEPTH-1:0] match1, match2;

  assign head_idx   = rd_ptr[AW-1:0];
  assign tail_idx   = wr_ptr[AW-1:0];
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (head_idx == tail_idx);
  assign lsu_ready  = !full && !reset;
  assign accept     = lsu_valid && lsu_ready;
  assign enq        = accept && (lsu_rd != 5'd0);
  // alu_valid is ignored during a forced drain, so a stall cycle always pops
  assign alu_win    = !alu_stall && alu_valid && (alu_rd != 5'd0);
  assign pop        = !alu_win && !empty;
  // ALU write is younger than a same-cycle LSU accept to the same register
  assign enq_killed = alu_win && (alu_rd == lsu_rd);

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[tail_idx]   <= lsu_rd;
      q_data[tail_idx] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_live     <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 5'd0;
      wr_data    <= 32'd0;
    end else begin
      wr_en     <= 1'b0;
      alu_stall <= 1'b0;
      if (alu_win) begin
        wr_en   <= 1'b1;
        wr_addr <= alu_rd;
        wr_data <= alu_data;
        for (int i = 0; i < DEPTH; i++) begin
          if (q_rd[i] == alu_rd) q_live[i] <= 1'b0;
        end
      end else if (pop) begin
        wr_en   <= q_live[head_idx];
        wr_addr <= q_rd[head_idx];
        wr_data <= q_data[head_idx];
      end
      if (pop) begin
        q_live[head_idx] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (enq) begin
        q_live[tail_idx] <= !enq_killed;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (alu_win) begin
        starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt == CW'(STARVE_MAX - 1)) alu_stall <= 1'b1;
      end
    end
  end

  // match bits are indexed by age: bit 0 is the head (oldest)
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW'(k) < count) && q_live[head_idx + AW'(k)]) begin
        match1[k] = (rd_addr1 != 5'd0) && (q_rd[head_idx + AW'(k)] == rd_addr1);
        match2[k] = (rd_addr2 != 5'd0) && (q_rd[head_idx + AW'(k)] == rd_addr2);
      end
    end
  end

  assign pend_hit1 = |match1;
  assign pend_hit2 = |match2;

`ifdef WB_BYPASS_EN
  always_comb begin
    byp_data1 = 32'd0;
    byp_data2 = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[k]) byp_data1 = q_data[head_idx + AW'(k)];
      if (match2[k]) byp_data2 = q_data[head_idx + AW'(k)];
    end
  end
  assign byp_valid1 = pend_hit1;
  assign byp_valid2 = pend_hit2;
`else
  assign byp_valid1 = 1'b0;
  assign byp_valid2 = 1'b0;
  assign byp_data1  = 32'd0;
  assign byp_data2  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_write_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_stall, lsu_ready, wr_en, pend_hit1, pend_hit2, byp_valid1, byp_valid2;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, byp_data1, byp_data2;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .byp_valid1(byp_valid1), .byp_valid2(byp_valid2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_stall, m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  int          m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_lookup(input logic [4:0] r, output logic hit, output logic [31:0] dat);
    hit = 1'b0;
    dat = 32'd0;
    if (r != 5'd0) begin
      foreach (mq[i]) begin
        if (mq[i].live && mq[i].rd == r) begin
          hit = 1'b1;
          dat = mq[i].data;
        end
      end
    end
  endfunction

  // Called just after a negedge: drives inputs, checks outputs, advances the model to the next cycle.
  task automatic do_cycle(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    logic        exp_ready, h1, h2, acc, win, pop, nstall;
    logic [31:0] d1, d2;
    int          sz;
    ent_t        e;
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    #1;
    exp_ready = !rst && (mq.size() < DEPTH);
    check_eq("alu_stall", alu_stall, m_stall);
    check_eq("lsu_ready", lsu_ready, exp_ready);
    check_eq("wr_en", wr_en, m_wr_en);
    if (m_wr_en) begin
      check_eq("wr_addr", wr_addr, m_wr_addr);
      check_eq("wr_data", wr_data, m_wr_data);
    end
    ref_lookup(rd_addr1, h1, d1);
    ref_lookup(rd_addr2, h2, d2);
    check_eq("pend_hit1", pend_hit1, h1);
    check_eq("pend_hit2", pend_hit2, h2);
`ifdef WB_BYPASS_EN
    check_eq("byp_valid1", byp_valid1, h1);
    check_eq("byp_valid2", byp_valid2, h2);
    if (h1) check_eq("byp_data1", byp_data1, d1);
    if (h2) check_eq("byp_data2", byp_data2, d2);
`else
    check_eq("byp_valid1", byp_valid1, 1'b0);
    check_eq("byp_valid2", byp_valid2, 1'b0);
    check_eq("byp_data1", byp_data1, 32'd0);
    check_eq("byp_data2", byp_data2, 32'd0);
`endif
    if (rst) begin
      mq.delete();
      m_stall = 1'b0;
      m_cnt   = 0;
      m_wr_en = 1'b0;
    end else begin
      sz      = mq.size();
      acc     = lv && exp_ready;
      win     = !m_stall && av && (ard != 5'd0);
      pop     = !win && (sz > 0);
      nstall  = 1'b0;
      m_wr_en = 1'b0;
      if (win) begin
        m_wr_en = 1'b1; m_wr_addr = ard; m_wr_data = adat;
        foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      end else if (pop) begin
        e = mq.pop_front();
        m_wr_en = e.live; m_wr_addr = e.rd; m_wr_data = e.data;
      end
      if (acc && lrd != 5'd0) mq.push_back('{!(win && ard == lrd), lrd, ldat});
      if (sz == 0 || pop) m_cnt = 0;
      else if (win) begin
        m_cnt++;
        if (m_cnt == STARVE_MAX) nstall = 1'b1;
      end
      m_stall = nstall;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int pa, pl;
    @(posedge clk);
    @(negedge clk);
    m_stall = 1'b0; m_cnt = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    check_eq("rst_wr_addr", wr_addr, 5'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    do_cycle(1'b1, 1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 32'h66);

    // single LSU write to x5, observed by read port 1
    rd_addr1 = 5'd5; rd_addr2 = 5'd0;
    do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    idle(3);

    // ALU every cycle while LSU fills the queue; starvation drain
    rd_addr1 = 5'd2; rd_addr2 = 5'd3;
    for (int i = 0; i < 14; i++)
      do_cycle(1'b0, 1'b1, 5'(20 + i % 8), $urandom, 1'b1, 5'(1 + i % 6), $urandom);
    idle(8);

    // WAW: queued x7 killed by a later ALU write
    rd_addr1 = 5'd7;
    do_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA);
    do_cycle(1'b0, 1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0);
    idle(3);

    // same-cycle accept and ALU write to x9
    rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    do_cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h9999);
    idle(3);

    // writes to x0 are dropped on both sides
    rd_addr1 = 5'd0;
    do_cycle(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    idle(2);

    // two queued x3 values, youngest should bypass
    rd_addr1 = 5'd3; rd_addr2 = 5'd1;
    do_cycle(1'b0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd3, 32'h1);
    do_cycle(1'b0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd3, 32'h2);
    do_cycle(1'b0, 1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 32'd0);
    idle(4);

    // reset with three entries queued
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 5'd13, 32'h13, 1'b1, 5'(1 + i), 32'(i + 100));
    do_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    do_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);

    // random traffic, phased ALU/LSU load to exercise full, starvation and WAW
    for (int ph = 0; ph < 6; ph++) begin
      pa = (ph % 3 == 0) ? 95 : (ph % 3 == 1) ? 50 : 20;
      pl = (ph < 3) ? 70 : 40;
      for (int c = 0; c < 400; c++) begin
        rd_addr1 = 5'($urandom_range(0, 7));
        rd_addr2 = 5'($urandom_range(0, 7));
        do_cycle(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < pa), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < pl), 5'($urandom_range(0, 7)), $urandom);
      end
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
